// File: rtl/add_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin add arbiter.
package add_arb_pkg;

  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_IDW       = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ADD  = ST_ADD,
    RESP = ST_RESP
  } state_t;

endpackage

// File: rtl/add_arbiter_if.sv
// Requester and response channels of the add arbiter, bundled for port hookup.
interface add_arbiter_if
  import add_arb_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int IDW       = DEF_IDW
) ();

  // Handshake: a transfer happens at a rising edge where valid and ready are both
  // high. The source holds valid and payload stable until it sees ready; ready may
  // depend combinationally on valid, valid never depends on ready.
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DATAWIDTH-1:0] req_a;
  logic [NUM_REQ*DATAWIDTH-1:0] req_b;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [DATAWIDTH-1:0]         rsp_sum;
  logic [IDW-1:0]               rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

endinterface

// File: rtl/add_arbiter_add.sv
// Shared combinational adder; carry out is dropped so the sum wraps.
module add_arbiter_add
  import add_arb_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters; one op in flight,
// result returned on a single tagged response channel with backpressure.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int IDW       = DEF_IDW
) (
  input  logic          Clk,
  input  logic          Rst_n,
  add_arbiter_if.slave  bus,
  output logic          busy,
  output state_t        state_dbg
);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 16 || (2 ** IDW) < NUM_REQ) begin : g_bad_params
      $error("add_arbiter: NUM_REQ must be 2..16 and fit in IDW bits");
    end
  endgenerate

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q;
  logic [DATAWIDTH-1:0] op_a_q, op_b_q;
  logic [IDW-1:0]       id_q;
  logic                 rsp_valid_q;
  logic [DATAWIDTH-1:0] rsp_sum_q;
  logic [IDW-1:0]       rsp_id_q;

  logic [NUM_REQ-1:0]   grant;
  logic [IDW:0]         pick;
  logic [IDW-1:0]       win;
  logic                 accept, load_rsp, rsp_done;
  logic [DATAWIDTH-1:0] sum;

  logic [DATAWIDTH-1:0] a_arr [NUM_REQ];
  logic [DATAWIDTH-1:0] b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = bus.req_a[gi*DATAWIDTH +: DATAWIDTH];
    assign b_arr[gi] = bus.req_b[gi*DATAWIDTH +: DATAWIDTH];
  end

  // Returns {found, index}. Scanning offsets from far to near lets the nearest
  // valid requester after ptr overwrite any farther one, so no early exit is needed.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IDW-1:0]     ptr);
    logic [IDW:0] cand;
    logic [IDW:0] res;
    res = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = {1'b0, ptr} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (valid[cand[IDW-1:0]]) begin
        res = {1'b1, cand[IDW-1:0]};
      end
    end
    return res;
  endfunction

  add_arbiter_add #(
    .DATAWIDTH (DATAWIDTH)
  ) u_add (
    .a   (op_a_q),
    .b   (op_b_q),
    .sum (sum)
  );

  assign win = pick[IDW-1:0];

  always_comb begin
    state_d  = state_q;
    grant    = '0;
    accept   = 1'b0;
    load_rsp = 1'b0;
    rsp_done = 1'b0;
    pick     = rr_pick(bus.req_valid, ptr_q);
    case (state_q)
      IDLE: begin
        if (pick[IDW]) begin
          grant[win] = 1'b1;
          accept     = 1'b1;
          state_d    = ADD;
        end
      end
      ADD: begin
        load_rsp = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the last requester so requester 0 is first in line.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NUM_REQ - 1);
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a_q <= a_arr[win];
        op_b_q <= b_arr[win];
        id_q   <= win;
        ptr_q  <= win;
      end
      if (load_rsp) begin
        rsp_sum_q   <= sum;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized bench for add_arbiter: cycle-level reference model plus a response scoreboard.
module tb_add_arbiter;
  import add_arb_pkg::*;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic   Clk = 1'b0;
  logic   Rst_n;
  logic   busy;
  state_t state_dbg;

  add_arbiter_if #(.DATAWIDTH(DW), .NUM_REQ(NR), .IDW(IW)) bus ();

  add_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR), .IDW(IW)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [IW+DW-1:0] exp_q[$];
  int grant_log[$];
  int grant_cyc[$];

  // reference model: one operation outstanding, age = edges since acceptance
  bit in_flight = 1'b0;
  int age       = 0;
  int last      = NR - 1;
  bit refill    = 1'b0;

  logic [NR-1:0] snap_ready;
  logic          snap_valid, snap_busy;
  logic [DW-1:0] snap_sum;
  logic [IW-1:0] snap_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = (longint'(a) + longint'(b)) % (longint'(1) << DW);
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // model and protocol checks, evaluated mid-cycle while inputs are stable
  always @(negedge Clk) begin
    logic [NR-1:0] exp_rdy;
    int            win;
    state_t        exp_st;
    cyc++;
    if (Rst_n !== 1'b1) begin
      in_flight = 1'b0;
      age       = 0;
      last      = NR - 1;
      exp_q.delete();
    end else begin
      win = -1;
      if (!in_flight) begin
        for (int k = 1; k <= NR; k++) begin
          int j;
          j = (last + k) % NR;
          if (win < 0 && (bus.req_valid & (NR'(1) << j)) != '0) win = j;
        end
      end
      exp_rdy = (win >= 0) ? (NR'(1) << win) : '0;
      exp_st  = !in_flight ? IDLE : (age < 2 ? ADD : RESP);
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      check("busy", 64'(busy), 64'(in_flight));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(in_flight && age >= 2));
      check("state", 64'(state_dbg), 64'(exp_st));
      for (int i = 0; i < NR; i++) begin
        if (bus.req_ready == (NR'(1) << i)) begin
          grant_log.push_back(i);
          grant_cyc.push_back(cyc);
        end
      end
      if (in_flight) begin
        if (age >= 2 && bus.rsp_ready === 1'b1) in_flight = 1'b0;
        else if (age < 2) age++;
      end else if (win >= 0) begin
        in_flight = 1'b1;
        age       = 1;
        last      = win;
        exp_q.push_back({IW'(win), ref_sum(bus.req_a[win*DW +: DW], bus.req_b[win*DW +: DW])});
      end
    end
  end

  // response monitor: every cycle a result is presented it must match the head entry
  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: cycle %0d got id %0h sum %0h, expected no response",
                 cyc, bus.rsp_id, bus.rsp_sum);
      end else begin
        check("rsp_sum", 64'(bus.rsp_sum), 64'(exp_q[0][DW-1:0]));
        check("rsp_id", 64'(bus.rsp_id), 64'(exp_q[0][IW+DW-1:DW]));
        if (bus.rsp_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  task automatic raise(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
    bus.req_valid         = bus.req_valid | (NR'(1) << i);
  endtask

  // one clock: snapshot outputs mid-cycle, then retire whoever was granted
  task automatic step();
    @(negedge Clk);
    snap_ready = bus.req_ready;
    snap_valid = bus.rsp_valid;
    snap_sum   = bus.rsp_sum;
    snap_id    = bus.rsp_id;
    snap_busy  = busy;
    @(posedge Clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if ((snap_ready & (NR'(1) << i)) != '0) begin
        bus.req_valid = bus.req_valid & ~(NR'(1) << i);
        if (refill) raise(i, $urandom, $urandom);
      end
    end
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    Rst_n = 1'b0;
    step();
    step();
    Rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    bus.rsp_ready = 1'b1;
    step();
    while ((bus.req_valid != '0 || exp_q.size() != 0 || snap_busy) && budget > 0) begin
      step();
      budget--;
    end
    check("drain_done", 64'(budget == 0), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    Rst_n = 1'b1;

    step();
    check("reset_rsp_valid", 64'(snap_valid), 64'(0));
    check("reset_rsp_sum", 64'(snap_sum), 64'(0));
    check("reset_rsp_id", 64'(snap_id), 64'(0));
    check("reset_busy", 64'(snap_busy), 64'(0));

    // single request from requester 0
    bus.rsp_ready = 1'b1;
    raise(0, 32'd5, 32'd7);
    step();
    check("t1_grant", 64'(snap_ready), 64'(4'b0001));
    check("t1_busy_idle", 64'(snap_busy), 64'(0));
    step();
    check("t1_busy_add", 64'(snap_busy), 64'(1));
    check("t1_valid_add", 64'(snap_valid), 64'(0));
    step();
    check("t1_valid", 64'(snap_valid), 64'(1));
    check("t1_sum", 64'(snap_sum), 64'(12));
    check("t1_id", 64'(snap_id), 64'(0));
    step();
    check("t1_busy_after", 64'(snap_busy), 64'(0));

    // carry out discarded
    raise(1, 32'hFFFF_FFFF, 32'd2);
    step();
    check("t2_grant", 64'(snap_ready), 64'(4'b0010));
    step();
    step();
    check("t2_sum", 64'(snap_sum), 64'(32'h0000_0001));
    check("t2_id", 64'(snap_id), 64'(1));
    step();

    // fairness with everyone continuously valid
    do_reset();
    grant_log.delete();
    grant_cyc.delete();
    refill = 1'b1;
    for (int i = 0; i < NR; i++) raise(i, $urandom, $urandom);
    repeat (15) step();
    refill = 1'b0;
    drain(100);
    check("fair_count", 64'(grant_log.size() >= 5), 64'(1));
    if (grant_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("fair_order", 64'(grant_log[k]), 64'(k % NR));
      for (int k = 1; k < 5; k++) check("fair_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'(3));
    end

    // backpressure: result held, nobody granted, then regrant one cycle after handshake
    bus.rsp_ready = 1'b0;
    raise(2, $urandom, $urandom);
    step();
    step();
    step();
    check("bp_valid", 64'(snap_valid), 64'(1));
    raise(0, $urandom, $urandom);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_ready_low", 64'(snap_ready), 64'(0));
      check("bp_hold_valid", 64'(snap_valid), 64'(1));
      check("bp_hold_id", 64'(snap_id), 64'(2));
    end
    bus.rsp_ready = 1'b1;
    step();
    step();
    check("bp_regrant", 64'(snap_ready), 64'(4'b0001));
    drain(50);

    // pointer wrap
    raise(3, $urandom, $urandom);
    step();
    check("pw_first", 64'(snap_ready), 64'(4'b1000));
    step();
    step();
    raise(1, $urandom, $urandom);
    raise(3, $urandom, $urandom);
    step();
    check("pw_after3", 64'(snap_ready), 64'(4'b0010));
    raise(1, $urandom, $urandom);
    step();
    step();
    step();
    check("pw_after1", 64'(snap_ready), 64'(4'b1000));
    drain(50);

    // reset while a result is waiting
    bus.rsp_ready = 1'b0;
    raise(1, $urandom, $urandom);
    step();
    step();
    step();
    check("mr_resp", 64'(snap_valid), 64'(1));
    Rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    Rst_n = 1'b1;
    step();
    check("mr_valid", 64'(snap_valid), 64'(0));
    check("mr_sum", 64'(snap_sum), 64'(0));
    check("mr_id", 64'(snap_id), 64'(0));
    check("mr_busy", 64'(snap_busy), 64'(0));
    raise(2, 32'd100, 32'd23);
    step();
    check("mr_grant", 64'(snap_ready), 64'(4'b0100));
    step();
    step();
    check("mr_rsp_valid", 64'(snap_valid), 64'(1));
    check("mr_rsp_id", 64'(snap_id), 64'(2));
    check("mr_rsp_sum", 64'(snap_sum), 64'(123));
    step();

    // random traffic with random backpressure
    for (int n = 0; n < 800; n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if ((bus.req_valid & (NR'(1) << i)) == '0 && $urandom_range(0, 2) == 0)
          raise(i, rand_op(), rand_op());
      end
      step();
    end
    drain(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
